stage_ic_buffer: RTL and testbench

Complete-stage result buffer that sits directly downstream of the execute stage.
- Captures each valid execute result (ALU/mult/load/branch) into a small in-order FIFO.
- Broadcasts one entry per cycle on the common data bus (CDB) when the CDB arbiter grants.
- The CDB carries PRF/RS wakeup data and ROB completion data.
- Back-pressures execute with ex_ready and drops all contents on a squash.

---
 rtl/stage_ic_buffer.sv | 151 +++++++++++++++
 tb/tb_stage_ic_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ic_buffer.sv
// Complete-stage result buffer: in-order FIFO between execute and the CDB.
// Optional same-cycle execute-to-CDB bypass when empty: define IC_BYPASS_EN.
module stage_ic_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int ROB_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic                     ex_valid,
    input  logic [XLEN-1:0]          ex_result,
    input  logic [XLEN-1:0]          ex_target,
    input  logic                     ex_take_branch,
    input  logic [TAG_W-1:0]         ex_tag,
    input  logic                     ex_tag_valid,
    input  logic [ROB_W-1:0]         ex_rob_idx,
    input  logic                     ex_halt,
    input  logic                     ex_illegal,
    output logic                     ex_ready,
    input  logic                     cdb_grant,
    output logic                     cdb_valid,
    output logic [XLEN-1:0]          cdb_data,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic                     cdb_tag_valid,
    output logic [ROB_W-1:0]         cdb_rob_idx,
    output logic                     cdb_take_branch,
    output logic [XLEN-1:0]          cdb_target,
    output logic                     cdb_halt,
    output logic                     cdb_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  target;
        logic             take_branch;
        logic [TAG_W-1:0] tag;
        logic             tag_valid;
        logic [ROB_W-1:0] rob_idx;
        logic             halt;
        logic             illegal;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           ex_entry;
    entry_t           cdb_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             occupied;
    logic             push;
    logic             pop;

    always_comb begin
        ex_entry.result      = ex_result;
        ex_entry.target      = ex_target;
        ex_entry.take_branch = ex_take_branch;
        ex_entry.tag         = ex_tag;
        ex_entry.tag_valid   = ex_tag_valid;
        ex_entry.rob_idx     = ex_rob_idx;
        ex_entry.halt        = ex_halt;
        ex_entry.illegal     = ex_illegal;
    end

    // Back-pressure comes from the registered count only, never from cdb_grant.
    assign occupied = (count != '0);
    assign ex_ready = (count < FULL_CNT);

`ifdef IC_BYPASS_EN
    logic bypass_hit;

    // An empty buffer forwards execute straight to the CDB; a granted bypass is consumed.
    assign bypass_hit = !occupied && ex_valid && !squash;
    assign cdb_valid  = (occupied || ex_valid) && !squash;
    assign cdb_entry  = occupied ? mem[head] : ex_entry;
    assign push       = ex_valid && ex_ready && !squash && !(bypass_hit && cdb_grant);
`else
    assign cdb_valid  = occupied && !squash;
    assign cdb_entry  = mem[head];
    assign push       = ex_valid && ex_ready && !squash;
`endif

    // Pop only real entries, so a grant to a bypassed result leaves the pointers alone.
    assign pop = occupied && cdb_grant && !squash;

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        cdb_data        = '0;
        cdb_tag         = '0;
        cdb_tag_valid   = 1'b0;
        cdb_rob_idx     = '0;
        cdb_take_branch = 1'b0;
        cdb_target      = '0;
        cdb_halt        = 1'b0;
        cdb_illegal     = 1'b0;
        if (cdb_valid) begin
            cdb_data        = cdb_entry.result;
            cdb_tag         = cdb_entry.tag;
            cdb_tag_valid   = cdb_entry.tag_valid && !cdb_entry.illegal
                              && (cdb_entry.tag != '0);
            cdb_rob_idx     = cdb_entry.rob_idx;
            cdb_take_branch = cdb_entry.take_branch;
            cdb_target      = cdb_entry.target;
            cdb_halt        = cdb_entry.halt;
            cdb_illegal     = cdb_entry.illegal;
        end
    end

    // NOTE: the storage array is not reset; stale slots are unreachable because
    // count gates cdb_valid and every cdb_* field is masked to 0 when invalid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[tail] <= ex_entry;
        end
    end

    // NOTE: all state updates use non-blocking assignments so reads within the
    // same edge see the pre-edge values of head, tail and count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_ic_buffer.sv
// Directed self-checking bench for stage_ic_buffer; inputs change 1 ns after the
// rising edge and outputs are compared 2 ns after it.
module tb_stage_ic_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam int ROB_W = 5;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   squash;
    logic                   ex_valid;
    logic [XLEN-1:0]        ex_result;
    logic [XLEN-1:0]        ex_target;
    logic                   ex_take_branch;
    logic [TAG_W-1:0]       ex_tag;
    logic                   ex_tag_valid;
    logic [ROB_W-1:0]       ex_rob_idx;
    logic                   ex_halt;
    logic                   ex_illegal;
    logic                   ex_ready;
    logic                   cdb_grant;
    logic                   cdb_valid;
    logic [XLEN-1:0]        cdb_data;
    logic [TAG_W-1:0]       cdb_tag;
    logic                   cdb_tag_valid;
    logic [ROB_W-1:0]       cdb_rob_idx;
    logic                   cdb_take_branch;
    logic [XLEN-1:0]        cdb_target;
    logic                   cdb_halt;
    logic                   cdb_illegal;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_errors = 0;

    stage_ic_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_target(ex_target),
        .ex_take_branch(ex_take_branch), .ex_tag(ex_tag), .ex_tag_valid(ex_tag_valid),
        .ex_rob_idx(ex_rob_idx), .ex_halt(ex_halt), .ex_illegal(ex_illegal),
        .ex_ready(ex_ready), .cdb_grant(cdb_grant), .cdb_valid(cdb_valid),
        .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_tag_valid(cdb_tag_valid),
        .cdb_rob_idx(cdb_rob_idx), .cdb_take_branch(cdb_take_branch),
        .cdb_target(cdb_target), .cdb_halt(cdb_halt), .cdb_illegal(cdb_illegal),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_ex();
        ex_valid       = 1'b0;
        ex_result      = '0;
        ex_target      = '0;
        ex_take_branch = 1'b0;
        ex_tag         = '0;
        ex_tag_valid   = 1'b0;
        ex_rob_idx     = '0;
        ex_halt        = 1'b0;
        ex_illegal     = 1'b0;
    endtask

    task automatic drive_ex(input logic [XLEN-1:0] data, input logic [TAG_W-1:0] tag,
                            input logic [ROB_W-1:0] rob);
        idle_ex();
        ex_valid     = 1'b1;
        ex_result    = data;
        ex_tag       = tag;
        ex_tag_valid = 1'b1;
        ex_rob_idx   = rob;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        squash    = 1'b0;
        cdb_grant = 1'b0;
        idle_ex();

        // Reset, then idle
        cyc(); cyc(); settle();
        check("rst_count", count, 0);
        check("rst_valid", cdb_valid, 0);
        check("rst_ready", ex_ready, 1);
        reset = 1'b0;
        cyc(); settle();
        check("idle_valid", cdb_valid, 0);
        check("idle_count", count, 0);
        check("idle_ready", ex_ready, 1);
        check("idle_data", cdb_data, 0);

        // Single result with grant held
        drive_ex(32'h0000_1234, 6'd5, 5'd3);
        cdb_grant = 1'b1;
        settle();
`ifdef IC_BYPASS_EN
        check("single_byp_valid", cdb_valid, 1);
        check("single_byp_data", cdb_data, 32'h1234);
        check("single_byp_tagv", cdb_tag_valid, 1);
        cyc(); idle_ex(); settle();
        check("single_byp_count", count, 0);
        check("single_byp_after", cdb_valid, 0);
`else
        check("single_same_cycle", cdb_valid, 0);
        cyc(); idle_ex(); settle();
        check("single_valid", cdb_valid, 1);
        check("single_data", cdb_data, 32'h1234);
        check("single_tag", cdb_tag, 5);
        check("single_rob", cdb_rob_idx, 3);
        check("single_tagv", cdb_tag_valid, 1);
        check("single_count1", count, 1);
        cyc(); settle();
        check("single_count0", count, 0);
        check("single_drained", cdb_valid, 0);
`endif
        check("single_data_zero", cdb_data, 0);

        // Fill with no grant, then back-pressure
        cdb_grant = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_ex(32'h10 + 32'(i), TAG_W'(8 + i), ROB_W'(i));
            cyc();
        end
        settle();
        check("fill_count", count, 4);
        check("fill_ready", ex_ready, 0);
        check("fill_head", cdb_data, 32'h10);
        drive_ex(32'h99, 6'd20, 5'd20);
        cyc(); idle_ex(); settle();
        check("full_ignored_count", count, 4);
        check("full_head_stable", cdb_data, 32'h10);
        cdb_grant = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", cdb_valid, 1);
            check("drain_data", cdb_data, 32'h10 + 32'(i));
            check("drain_tag", cdb_tag, 64'(8 + i));
            cyc(); settle();
            if (i == 0) check("ready_after_pop", ex_ready, 1);
        end
        check("drain_empty", count, 0);
        check("drain_no_valid", cdb_valid, 0);

        // Continuous push + grant through pointer wrap
        for (int i = 1; i <= 10; i++) begin
            drive_ex(32'(i), 6'd9, ROB_W'(i));
            settle();
`ifdef IC_BYPASS_EN
            check("wrap_byp_data", cdb_data, 64'(i));
            check("wrap_byp_count", count, 0);
`else
            if (i == 1) begin
                check("wrap_first_empty", cdb_valid, 0);
            end else begin
                check("wrap_data", cdb_data, 64'(i - 1));
                check("wrap_count", count, 1);
            end
`endif
            cyc();
        end
        idle_ex(); settle();
`ifndef IC_BYPASS_EN
        check("wrap_last", cdb_data, 10);
        cyc(); settle();
`endif
        check("wrap_empty", count, 0);

        // Illegal / tag-0 filtering, plus branch and halt fields
        cdb_grant = 1'b0;
        drive_ex(32'hAA, 6'd7, 5'd9);
        ex_illegal = 1'b1;
        cyc();
        drive_ex(32'hBB, 6'd0, 5'd10);
        cyc();
        drive_ex(32'hCC, 6'd12, 5'd11);
        ex_take_branch = 1'b1;
        ex_target      = 32'h8000_0040;
        ex_halt        = 1'b1;
        cyc(); idle_ex();
        cdb_grant = 1'b1;
        settle();
        check("illegal_valid", cdb_valid, 1);
        check("illegal_tagv", cdb_tag_valid, 0);
        check("illegal_rob", cdb_rob_idx, 9);
        check("illegal_flag", cdb_illegal, 1);
        cyc(); settle();
        check("tag0_valid", cdb_valid, 1);
        check("tag0_tagv", cdb_tag_valid, 0);
        check("tag0_rob", cdb_rob_idx, 10);
        cyc(); settle();
        check("br_tagv", cdb_tag_valid, 1);
        check("br_taken", cdb_take_branch, 1);
        check("br_target", cdb_target, 32'h8000_0040);
        check("br_halt", cdb_halt, 1);
        cyc(); settle();
        check("filter_empty", count, 0);

        // Squash with simultaneous push and grant
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_ex(32'h31 + 32'(i), 6'd4, ROB_W'(i));
            cyc();
        end
        drive_ex(32'h77, 6'd3, 5'd7);
        cdb_grant = 1'b1;
        squash    = 1'b1;
        settle();
        check("squash_valid", cdb_valid, 0);
        check("squash_data", cdb_data, 0);
        cyc(); squash = 1'b0; idle_ex(); settle();
        check("squash_count", count, 0);
        for (int i = 0; i < 3; i++) begin
            check("post_squash_quiet", cdb_valid, 0);
            cyc(); settle();
        end
        drive_ex(32'h44, 6'd2, 5'd1);
        settle();
`ifdef IC_BYPASS_EN
        check("post_squash_byp", cdb_data, 32'h44);
        cyc(); idle_ex(); settle();
`else
        check("post_squash_wait", cdb_valid, 0);
        cyc(); idle_ex(); settle();
        check("post_squash_data", cdb_data, 32'h44);
        cyc(); settle();
`endif
        check("post_squash_empty", count, 0);

        // Asynchronous reset in the middle of a cycle
        cdb_grant = 1'b0;
        drive_ex(32'h55, 6'd6, 5'd2);
        cyc();
        drive_ex(32'h56, 6'd6, 5'd3);
        cyc(); idle_ex(); settle();
        check("pre_reset_count", count, 2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_valid", cdb_valid, 0);
        check("async_rst_ready", ex_ready, 1);
        #1 reset = 1'b0;
        cyc(); settle();
        check("after_rst_valid", cdb_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
